latq_bank_wr_arb: RTL and testbench
===================================

LATQ_BANK_WR_ARB -- requirements
Module: latq_bank_wr_arb

Interface
REQ-001 Parameter NWORDS, default 8: number of latch words in the bank; legal range 2..16.
REQ-002 Parameter WIDTH, default 8: bits per latch word.
REQ-003 Parameter AW, default 4: address width; AW SHALL satisfy 2^AW >= NWORDS.
REQ-004 CLK  input  1  sole clock; all state updates on rising edge.
REQ-005 RST  input  1  synchronous, active-high reset.
REQ-006 REQ0  input  1  requester 0 write request, level; held until ACK0.
REQ-007 ADDR0  input  AW  requester 0 word address; stable while REQ0 high.
REQ-008 DATA0  input  WIDTH  requester 0 write data; stable while REQ0 high.
REQ-009 REQ1 / ADDR1 / DATA1  input  1 / AW / WIDTH  requester 1, same rules as requester 0.
REQ-010 ACK0, ACK1  output  1 each  one-cycle completion pulse to the granted requester.
REQ-011 ERR  output  1  valid with ACKn; high when the captured address was >= NWORDS.
REQ-012 LAT_E  output  NWORDS  one-hot latch enables, bit i drives E of word i.
REQ-013 LAT_D  output  WIDTH  shared data bus, drives D of every word.
REQ-014 BUSY  output  1  high in every state except IDLE.

Function
REQ-015 The block SHALL implement FSM states IDLE, SETUP, ENABLE, HOLD, plus HOLD2 when configured (REQ-033).
REQ-016 In IDLE with at least one REQn high, the block SHALL grant one requester, register its ADDR/DATA into internal registers, and go to SETUP.
REQ-017 Arbitration SHALL be round-robin: pointer PRI selects the preferred requester when both request; only one requesting -> that one wins regardless of PRI.
REQ-018 PRI SHALL move to the non-granted requester at each grant.
REQ-019 LAT_D SHALL equal the captured data from SETUP through the final hold state, and SHALL hold its last value otherwise.
REQ-020 LAT_E SHALL be all-zero in IDLE, SETUP and the hold states.
REQ-021 In ENABLE, LAT_E[addr] SHALL be 1 for exactly one cycle; all other bits SHALL be 0.
REQ-022 Captured address >= NWORDS: LAT_E SHALL stay zero throughout; the FSM sequence SHALL be unchanged; ERR SHALL be 1 with the ACK.
REQ-023 ACKn SHALL pulse in the final hold state; the FSM then SHALL return to IDLE.
REQ-024 Latency: capture edge to ACK SHALL be 3 cycles (4 with REQ-033), i.e. SETUP, ENABLE, HOLD.
REQ-025 There SHALL be a minimum of one IDLE cycle between consecutive grants; a requester dropping REQ in that cycle SHALL not be granted.
REQ-026 REQn changes while BUSY SHALL be ignored until the next IDLE; the captured ADDR/DATA SHALL not change mid-transaction.
REQ-027 A requester keeping REQn high after its ACK SHALL be treated as a new request in the next IDLE.
REQ-028 LAT_E SHALL be a registered output; glitch-free behaviour is required since it drives latch enables.

Reset
REQ-029 With RST high at a rising edge: FSM -> IDLE, LAT_E -> 0, LAT_D -> 0, ACK0/ACK1/ERR -> 0, BUSY -> 0, PRI -> requester 0.
REQ-030 RST asserted mid-transaction SHALL abort it: no ACK is issued, and LAT_E SHALL be 0 from the edge where RST is sampled.
REQ-031 A requester aborted by reset SHALL be regranted normally if REQ is still high after RST deasserts.

Configuration
REQ-032 Macro LATQ_WR_HOLD2_EN selects the hold phase length.
REQ-033 Defined: a HOLD2 state SHALL follow HOLD, LAT_D SHALL stay stable in it, and ACK SHALL move to HOLD2. Undefined: HOLD is final and ACK occurs in HOLD.

Verification
REQ-034 REQ0=1, ADDR0=3, DATA0=0xA5 from IDLE -> LAT_D=0xA5 at SETUP; LAT_E=0x08 for exactly one cycle at ENABLE; ACK0 at cycle 3; ERR=0.
REQ-035 REQ0, REQ1 high together and held, PRI=0 after reset -> grants alternate 0,1,0,1 with one IDLE cycle between ACK and the next SETUP.
REQ-036 REQ1=1, ADDR1=12, NWORDS=8 -> LAT_E stays 0x00 throughout; ACK1 and ERR pulse together at cycle 3.
REQ-037 RST pulsed during ENABLE of a write to addr 5 -> LAT_E=0 from the next edge; no ACK; with REQ held, the write is regranted and completes after reset.
REQ-038 ADDR0 changed from 2 to 6 during SETUP -> LAT_E=0x04 in ENABLE, i.e. the captured address is used.
REQ-039 With LATQ_WR_HOLD2_EN defined -> ACK at cycle 4; LAT_D stable through HOLD2; otherwise identical to REQ-034.

Source files
------------

// File: rtl/latq_bank_wr_arb_if.sv
// rtl/latq_bank_wr_arb_if.sv - requester and latch-bank signal bundle for latq_bank_wr_arb
interface latq_bank_wr_arb_if #(
    parameter int NWORDS = 8,
    parameter int WIDTH  = 8,
    parameter int AW     = 4
);
    logic              req0;
    logic [AW-1:0]     addr0;
    logic [WIDTH-1:0]  data0;
    logic              req1;
    logic [AW-1:0]     addr1;
    logic [WIDTH-1:0]  data1;
    logic              ack0;
    logic              ack1;
    logic              err;
    logic [NWORDS-1:0] lat_e;
    logic [WIDTH-1:0]  lat_d;
    logic              busy;

    modport master (
        output req0, addr0, data0, req1, addr1, data1,
        input  ack0, ack1, err, lat_e, lat_d, busy
    );

    modport slave (
        input  req0, addr0, data0, req1, addr1, data1,
        output ack0, ack1, err, lat_e, lat_d, busy
    );
endinterface

// File: rtl/latq_bank_wr_arb.sv
// rtl/latq_bank_wr_arb.sv - two-requester round-robin write arbiter for a latch bank (option: LATQ_WR_HOLD2_EN)
module latq_bank_wr_arb #(
    parameter int NWORDS = 8,
    parameter int WIDTH  = 8,
    parameter int AW     = 4
) (
    input  logic              clk,
    input  logic              rst,
    latq_bank_wr_arb_if.slave bus
);
    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] SETUP  = 3'd1;
    localparam logic [2:0] ENABLE = 3'd2;
    localparam logic [2:0] HOLD   = 3'd3;
    localparam logic [2:0] HOLD2  = 3'd4;

`ifdef LATQ_WR_HOLD2_EN
    // ACK/ERR are registered on the edge entering the final hold state
    localparam logic [2:0] ACK_SRC   = HOLD;
    localparam logic [2:0] HOLD_NEXT = HOLD2;
`else
    localparam logic [2:0] ACK_SRC   = ENABLE;
    localparam logic [2:0] HOLD_NEXT = IDLE;
`endif

    localparam logic [31:0] NW_U = NWORDS;

    logic [2:0]        state;
    logic              pri;      // 1: requester 1 preferred on a tie
    logic              gnt;      // requester owning the current transaction
    logic [AW-1:0]     addr_q;
    logic [WIDTH-1:0]  lat_d_q;
    logic [NWORDS-1:0] lat_e_q;
    logic [NWORDS-1:0] lat_e_n;
    logic              ack0_q;
    logic              ack1_q;
    logic              err_q;
    logic              pick1;
    logic              addr_ok;
    logic [31:0]       addr_ext;

    assign pick1    = bus.req1 & (~bus.req0 | pri);
    assign addr_ext = {{(32 - AW){1'b0}}, addr_q};
    assign addr_ok  = addr_ext < NW_U;

    // One-hot decode of the captured address; out-of-range addresses decode to zero
    always_comb begin
        lat_e_n = '0;
        for (int i = 0; i < NWORDS; i++) begin
            if (addr_ext == $unsigned(i)) begin
                lat_e_n[i] = 1'b1;
            end
        end
    end

    // Sequencer: capture in IDLE, enable pulse registered for a single cycle, ack at the end
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            pri     <= 1'b0;
            gnt     <= 1'b0;
            addr_q  <= '0;
            lat_d_q <= '0;
            lat_e_q <= '0;
            ack0_q  <= 1'b0;
            ack1_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            lat_e_q <= '0;
            ack0_q  <= 1'b0;
            ack1_q  <= 1'b0;
            err_q   <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.req0 | bus.req1) begin
                        gnt     <= pick1;
                        pri     <= ~pick1;
                        addr_q  <= pick1 ? bus.addr1 : bus.addr0;
                        lat_d_q <= pick1 ? bus.data1 : bus.data0;
                        state   <= SETUP;
                    end
                end
                SETUP: begin
                    lat_e_q <= lat_e_n;
                    state   <= ENABLE;
                end
                ENABLE:  state <= HOLD;
                HOLD:    state <= HOLD_NEXT;
                HOLD2:   state <= IDLE;
                default: state <= IDLE;
            endcase
            if (state == ACK_SRC) begin
                ack0_q <= ~gnt;
                ack1_q <= gnt;
                err_q  <= ~addr_ok;
            end
        end
    end

    assign bus.lat_e = lat_e_q;
    assign bus.lat_d = lat_d_q;
    assign bus.ack0  = ack0_q;
    assign bus.ack1  = ack1_q;
    assign bus.err   = err_q;
    assign bus.busy  = (state != IDLE);
endmodule

// File: tb/tb_latq_bank_wr_arb.sv
// tb/tb_latq_bank_wr_arb.sv - self-checking bench for latq_bank_wr_arb
module tb_latq_bank_wr_arb;
    localparam int NW = 8;
`ifdef LATQ_WR_HOLD2_EN
    localparam int LAST = 4;
`else
    localparam int LAST = 3;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int checks = 0;
    int failures = 0;

    latq_bank_wr_arb_if #(.NWORDS(NW), .WIDTH(8), .AW(4)) bus ();

    latq_bank_wr_arb #(.NWORDS(NW), .WIDTH(8), .AW(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // transaction-level model: cycles elapsed since the grant, plus the captured request
    int m_phase = 0;
    int m_pri = 0;
    int m_gnt = 0;
    int m_addr = 0;
    int m_d = 0;
    bit started = 0;

    always @(posedge clk) begin
        started = 1;
        if (rst) begin
            m_phase = 0;
            m_pri = 0;
            m_d = 0;
        end else if (m_phase == 0) begin
            if (bus.req0 || bus.req1) begin
                if (bus.req0 && bus.req1) m_gnt = m_pri;
                else m_gnt = bus.req1 ? 1 : 0;
                m_pri = 1 - m_gnt;
                m_addr = m_gnt ? int'(bus.addr1) : int'(bus.addr0);
                m_d = m_gnt ? int'(bus.data1) : int'(bus.data0);
                m_phase = 1;
            end
        end else if (m_phase == LAST) begin
            m_phase = 0;
        end else begin
            m_phase = m_phase + 1;
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // per-cycle compare against the model
    always @(negedge clk) begin
        if (started) begin
            int e_lat_e;
            bit fin;
            fin = (m_phase == LAST);
            e_lat_e = (m_phase == 2 && m_addr < NW) ? (1 << m_addr) : 0;
            chk("model_busy", int'(bus.busy), int'(m_phase != 0));
            chk("model_lat_e", int'(bus.lat_e), e_lat_e);
            chk("model_lat_d", int'(bus.lat_d), m_d);
            chk("model_ack0", int'(bus.ack0), int'(fin && m_gnt == 0));
            chk("model_ack1", int'(bus.ack1), int'(fin && m_gnt == 1));
            chk("model_err", int'(bus.err), int'(fin && m_addr >= NW));
        end
    end

    task automatic step(input int n);
        for (int k = 0; k < n; k++) @(negedge clk);
    endtask

    int ack_who[$];
    int ack_cyc[$];

    initial begin
        bus.req0 = 0; bus.addr0 = 0; bus.data0 = 0;
        bus.req1 = 0; bus.addr1 = 0; bus.data1 = 0;
        step(2);
        rst = 0;
        chk("reset_busy", int'(bus.busy), 0);
        chk("reset_lat_e", int'(bus.lat_e), 0);
        chk("reset_lat_d", int'(bus.lat_d), 0);
        chk("reset_acks", int'({bus.ack0, bus.ack1, bus.err}), 0);

        // basic write to word 3
        bus.req0 = 1; bus.addr0 = 4'd3; bus.data0 = 8'hA5;
        step(1);
        chk("w3_setup_lat_d", int'(bus.lat_d), 8'hA5);
        chk("w3_setup_lat_e", int'(bus.lat_e), 0);
        step(1);
        chk("w3_enable_lat_e", int'(bus.lat_e), 8'h08);
        step(1);
        chk("w3_after_enable_lat_e", int'(bus.lat_e), 0);
        step(LAST - 3);
        chk("w3_ack0", int'(bus.ack0), 1);
        chk("w3_err", int'(bus.err), 0);
        chk("w3_final_lat_d", int'(bus.lat_d), 8'hA5);
        bus.req0 = 0;
        step(2);
        chk("w3_idle_busy", int'(bus.busy), 0);

        // round-robin with both requesters held, starting from a fresh reset
        rst = 1;
        step(1);
        rst = 0;
        bus.req0 = 1; bus.addr0 = 4'd1; bus.data0 = 8'h11;
        bus.req1 = 1; bus.addr1 = 4'd2; bus.data1 = 8'h22;
        for (int c = 1; c <= 4 * (LAST + 1); c++) begin
            step(1);
            if (bus.ack0) begin ack_who.push_back(0); ack_cyc.push_back(c); end
            if (bus.ack1) begin ack_who.push_back(1); ack_cyc.push_back(c); end
        end
        bus.req0 = 0; bus.req1 = 0;
        chk("rr_ack_count", ack_who.size(), 4);
        if (ack_who.size() == 4) begin
            for (int i = 0; i < 4; i++) begin
                chk("rr_grant_order", ack_who[i], i % 2);
                chk("rr_ack_cycle", ack_cyc[i], LAST + i * (LAST + 1));
            end
        end
        step(LAST + 2);

        // out-of-range address from requester 1
        bus.req1 = 1; bus.addr1 = 4'd12; bus.data1 = 8'h5A;
        step(2);
        chk("oor_enable_lat_e", int'(bus.lat_e), 0);
        step(LAST - 2);
        chk("oor_ack1", int'(bus.ack1), 1);
        chk("oor_err", int'(bus.err), 1);
        chk("oor_ack0", int'(bus.ack0), 0);
        bus.req1 = 0;
        step(2);

        // reset during ENABLE, request held, regrant afterwards
        bus.req0 = 1; bus.addr0 = 4'd5; bus.data0 = 8'h3C;
        step(2);
        chk("rst_pre_lat_e", int'(bus.lat_e), 8'h20);
        rst = 1;
        step(1);
        chk("rst_lat_e", int'(bus.lat_e), 0);
        chk("rst_ack0", int'(bus.ack0), 0);
        chk("rst_busy", int'(bus.busy), 0);
        rst = 0;
        step(2);
        chk("regrant_lat_e", int'(bus.lat_e), 8'h20);
        step(LAST - 2);
        chk("regrant_ack0", int'(bus.ack0), 1);
        bus.req0 = 0;
        step(2);

        // address changes after capture, requester 1 blips while busy
        bus.req0 = 1; bus.addr0 = 4'd2; bus.data0 = 8'h77;
        step(1);
        bus.addr0 = 4'd6;
        bus.req1 = 1; bus.addr1 = 4'd7; bus.data1 = 8'h99;
        step(1);
        chk("cap_lat_e", int'(bus.lat_e), 8'h04);
        bus.req1 = 0;
        step(LAST - 2);
        chk("cap_ack0", int'(bus.ack0), 1);
        chk("cap_lat_d", int'(bus.lat_d), 8'h77);
        bus.req0 = 0;
        step(3);
        chk("cap_no_regrant", int'(bus.busy), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
